// File: rtl/three_phase_pkg.sv
// Shared constants and types for the three-phase center-aligned PWM generator.
package three_phase_pkg;

    localparam int DEF_CNT_W  = 10;
    localparam int DEF_PERIOD = 500;
    localparam int DEF_DEAD   = 10;

    localparam int DT_W   = 8;
    localparam int NUM_PH = 3;

    localparam int PH_A = 0;
    localparam int PH_B = 1;
    localparam int PH_C = 2;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/pwm_deadtime.sv
// One phase of complementary gate drive: tracks the raw compare and inserts
// a dead interval of DEAD+1 clocks before either side asserts.
module pwm_deadtime
    import three_phase_pkg::*;
#(
    parameter int DEAD = DEF_DEAD
) (
    input  logic clk10mhz,
    input  logic nRst,
    input  logic run,
    input  logic raw,
    output logic H,
    output logic L
);

    localparam logic [DT_W-1:0] DT_INIT = DT_W'(DEAD);

    logic            target;
    logic [DT_W-1:0] dt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk10mhz or negedge nRst) begin
        if (!nRst) begin
            target <= 1'b0;
            dt     <= DT_INIT;
            H      <= 1'b0;
            L      <= 1'b0;
        end else if (!run) begin
            target <= 1'b0;
            dt     <= DT_INIT;
            H      <= 1'b0;
            L      <= 1'b0;
        end else if (raw != target) begin
            // Any change, even a short glitch, restarts the dead interval.
            target <= raw;
            dt     <= DT_INIT;
            H      <= 1'b0;
            L      <= 1'b0;
        end else if (dt != '0) begin
            dt <= dt - 1'b1;
            H  <= 1'b0;
            L  <= 1'b0;
        end else begin
            H <= target;
            L <= ~target;
        end
    end

endmodule

// File: rtl/three_phase_pwm_gen.sv
// Center-aligned three-phase PWM with shadow/active duty buffering,
// per-phase dead time and a sticky fault that forces every gate low.
module three_phase_pwm_gen
    import three_phase_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int PERIOD = DEF_PERIOD,
    parameter int DEAD   = DEF_DEAD
) (
    input  logic             clk10mhz,
    input  logic             nRst,
    input  logic             enable,
    input  logic             dutyWr,
    input  logic [CNT_W-1:0] dutyA,
    input  logic [CNT_W-1:0] dutyB,
    input  logic [CNT_W-1:0] dutyC,
    input  logic             fault,
    input  logic             faultClr,
    output logic [2:0]       pwmH,
    output logic [2:0]       pwmL,
    output logic             syncPulse,
    output logic             faultLatched
);

    localparam logic [CNT_W-1:0] PEAK = CNT_W'(PERIOD);

    logic                             run;
    logic                             gateRun;
    logic [CNT_W-1:0]                 cnt;
    dir_t                             dir;
    logic [NUM_PH-1:0][CNT_W-1:0]     dutyIn;
    logic [NUM_PH-1:0][CNT_W-1:0]     shadow;
    logic [NUM_PH-1:0][CNT_W-1:0]     active;
    logic [NUM_PH-1:0]                raw;

    function automatic logic [CNT_W-1:0] clampDuty(input logic [CNT_W-1:0] d);
        return (d > PEAK) ? PEAK : d;
    endfunction

    // NOTE: every signal written here gets a value on every path, so no
    // latch can be inferred.
    always_comb begin
        run            = enable & ~faultLatched;
        // A fault sampled this edge must already blank the gates.
        gateRun        = run & ~fault;
        dutyIn[PH_A]   = dutyA;
        dutyIn[PH_B]   = dutyB;
        dutyIn[PH_C]   = dutyC;
        for (int i = 0; i < NUM_PH; i++) begin
            raw[i] = (cnt < active[i]);
        end
    end

    always_ff @(posedge clk10mhz or negedge nRst) begin
        if (!nRst) begin
            faultLatched <= 1'b0;
        end else begin
            faultLatched <= fault | (faultLatched & ~faultClr);
        end
    end

    always_ff @(posedge clk10mhz or negedge nRst) begin
        if (!nRst) begin
            shadow <= '0;
        end else if (dutyWr) begin
            for (int i = 0; i < NUM_PH; i++) begin
                shadow[i] <= clampDuty(dutyIn[i]);
            end
        end
    end

    // Triangle carrier; active duty reloads at the bottom so all three
    // phases switch to new values symmetrically within one period.
    always_ff @(posedge clk10mhz or negedge nRst) begin
        if (!nRst) begin
            cnt       <= '0;
            dir       <= DIR_UP;
            active    <= '0;
            syncPulse <= 1'b0;
        end else begin
            syncPulse <= run && (cnt == '0);
            if (!run) begin
                cnt <= '0;
                dir <= DIR_UP;
            end else begin
                if (cnt == '0) begin
                    active <= shadow;
                end
                if (dir == DIR_UP) begin
                    if (cnt == PEAK) begin
                        cnt <= cnt - 1'b1;
                        dir <= DIR_DOWN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    if (cnt == '0) begin
                        cnt <= cnt + 1'b1;
                        dir <= DIR_UP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_PH; i++) begin : g_phase
        pwm_deadtime #(
            .DEAD(DEAD)
        ) u_deadtime (
            .clk10mhz(clk10mhz),
            .nRst    (nRst),
            .run     (gateRun),
            .raw     (raw[i]),
            .H       (pwmH[i]),
            .L       (pwmL[i])
        );
    end

endmodule

// File: tb/tb_three_phase_pwm_gen.sv
// Randomized bench for three_phase_pwm_gen against a windowed reference model
// built from the carrier formula and the dead-time stability rule.
module tb_three_phase_pwm_gen;

    localparam int P  = 500;
    localparam int D  = 10;
    localparam int CW = 10;
    localparam int HN = D + 2;

    logic          clk10mhz = 1'b0;
    logic          nRst;
    logic          enable;
    logic          dutyWr;
    logic [CW-1:0] dutyA;
    logic [CW-1:0] dutyB;
    logic [CW-1:0] dutyC;
    logic          fault;
    logic          faultClr;
    logic [2:0]    pwmH;
    logic [2:0]    pwmL;
    logic          syncPulse;
    logic          faultLatched;

    int total = 0;
    int bad   = 0;

    // Reference model state: edges run since carrier start, duty buffers,
    // and a per-edge history of (gate run, raw compare) for the window rule.
    int       mK;
    int       mShadow[3];
    int       mActive[3];
    bit       mFl;
    bit       mSync;
    bit       runHist[HN];
    bit       rawHist[3][HN];
    bit [2:0] expH;
    bit [2:0] expL;

    three_phase_pwm_gen #(
        .CNT_W (CW),
        .PERIOD(P),
        .DEAD  (D)
    ) dut (
        .clk10mhz    (clk10mhz),
        .nRst        (nRst),
        .enable      (enable),
        .dutyWr      (dutyWr),
        .dutyA       (dutyA),
        .dutyB       (dutyB),
        .dutyC       (dutyC),
        .fault       (fault),
        .faultClr    (faultClr),
        .pwmH        (pwmH),
        .pwmL        (pwmL),
        .syncPulse   (syncPulse),
        .faultLatched(faultLatched)
    );

    always #50 clk10mhz = ~clk10mhz;

    initial begin
        #8000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Carrier value after k consecutive running edges.
    function automatic int tri_f(input int k);
        int p;
        p = k % (2 * P);
        return (p <= P) ? p : (2 * P - p);
    endfunction

    function automatic int clamp(input int d);
        return (d > P) ? P : d;
    endfunction

    task automatic model_reset();
        mK    = 0;
        mFl   = 1'b0;
        mSync = 1'b0;
        expH  = '0;
        expL  = '0;
        for (int i = 0; i < 3; i++) begin
            mShadow[i] = 0;
            mActive[i] = 0;
        end
        for (int j = 0; j < HN; j++) begin
            runHist[j] = 1'b0;
            for (int i = 0; i < 3; i++) rawHist[i][j] = 1'b0;
        end
    endtask

    // A gate side is on after an edge when the last D+1 edges all ran with
    // raw at its level and the edge before them settled on that same level
    // (an idle edge counts as settling low).
    task automatic model_edge();
        bit run;
        bit grun;
        int c;
        bit rawv[3];
        bit allRun;
        bit all1;
        bit all0;
        if (!nRst) begin
            model_reset();
            return;
        end
        run  = enable && !mFl;
        grun = run && !fault;
        c    = tri_f(mK);
        for (int i = 0; i < 3; i++) rawv[i] = (c < mActive[i]);
        for (int j = HN - 1; j > 0; j--) begin
            runHist[j] = runHist[j-1];
            for (int i = 0; i < 3; i++) rawHist[i][j] = rawHist[i][j-1];
        end
        runHist[0] = grun;
        for (int i = 0; i < 3; i++) rawHist[i][0] = rawv[i];
        mSync = run && (c == 0);
        if (run) begin
            if (c == 0) begin
                for (int i = 0; i < 3; i++) mActive[i] = mShadow[i];
            end
            mK++;
        end else begin
            mK = 0;
        end
        if (dutyWr) begin
            mShadow[0] = clamp(int'(dutyA));
            mShadow[1] = clamp(int'(dutyB));
            mShadow[2] = clamp(int'(dutyC));
        end
        mFl = fault || (mFl && !faultClr);
        for (int i = 0; i < 3; i++) begin
            allRun = 1'b1;
            all1   = 1'b1;
            all0   = 1'b1;
            for (int j = 0; j <= D; j++) begin
                allRun = allRun && runHist[j];
                all1   = all1 && rawHist[i][j];
                all0   = all0 && !rawHist[i][j];
            end
            expH[i] = allRun && all1 && runHist[D+1] && rawHist[i][D+1];
            expL[i] = allRun && all0 && !(runHist[D+1] && rawHist[i][D+1]);
        end
    endtask

    task automatic compare_outputs();
        check("pwmH", 32'(pwmH), 32'(expH));
        check("pwmL", 32'(pwmL), 32'(expL));
        check("syncPulse", 32'(syncPulse), 32'(mSync));
        check("faultLatched", 32'(faultLatched), 32'(mFl));
        check("overlap", 32'(pwmH & pwmL), 32'd0);
    endtask

    task automatic cycle();
        @(posedge clk10mhz);
        model_edge();
        @(negedge clk10mhz);
        compare_outputs();
    endtask

    task automatic run_cycles(input int n);
        repeat (n) cycle();
    endtask

    task automatic write_duty(input int a, input int b, input int c);
        dutyA  = CW'(a);
        dutyB  = CW'(b);
        dutyC  = CW'(c);
        dutyWr = 1'b1;
        cycle();
        dutyWr = 1'b0;
    endtask

    // Advance until the next edge is a running carrier-bottom edge.
    task automatic wait_bottom();
        int g;
        g = 0;
        while (tri_f(mK) != 0 || !(enable && !mFl)) begin
            cycle();
            g++;
            if (g > 1100) begin
                check("bottom_timeout", 32'(g), 32'd0);
                break;
            end
        end
    endtask

    function automatic int pick_duty();
        int r;
        r = $urandom_range(0, 5);
        case (r)
            0:       return 0;
            1:       return P;
            2:       return $urandom_range(P + 1, 1023);
            3:       return $urandom_range(1, 4);
            default: return $urandom_range(0, P);
        endcase
    endfunction

    initial begin
        int n;
        nRst     = 1'b0;
        enable   = 1'b0;
        dutyWr   = 1'b0;
        dutyA    = '0;
        dutyB    = '0;
        dutyC    = '0;
        fault    = 1'b0;
        faultClr = 1'b0;
        model_reset();
        run_cycles(3);
        nRst = 1'b1;
        run_cycles(3);

        // Enable with zero duty: low sides settle after DEAD+1 clocks.
        enable = 1'b1;
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (pwmL === 3'b111) begin
                n = i;
                break;
            end
        end
        check("l_delay", 32'(n), 32'(D + 1));
        run_cycles(2100);

        // Mid-period write waits for the next bottom.
        run_cycles($urandom_range(100, 400));
        write_duty(250, 0, 0);
        run_cycles(2500);

        // Write on the bottom edge lands one period late; 700 clamps to peak.
        wait_bottom();
        write_duty(P, 700, 123);
        run_cycles(3000);

        // One-cycle fault while phase A conducts high.
        run_cycles(300);
        fault = 1'b1;
        cycle();
        fault = 1'b0;
        check("fault_set", 32'(faultLatched), 32'd1);
        check("fault_gates", 32'(pwmH | pwmL), 32'd0);
        run_cycles(5);
        fault    = 1'b1;
        faultClr = 1'b1;
        cycle();
        fault = 1'b0;
        check("fault_hold", 32'(faultLatched), 32'd1);
        cycle();
        faultClr = 1'b0;
        check("fault_clr", 32'(faultLatched), 32'd0);
        run_cycles(1200);

        // Randomized duties, waits, fault pulses and enable drops.
        for (int it = 0; it < 12; it++) begin
            int r;
            r = $urandom_range(0, 7);
            write_duty(pick_duty(), pick_duty(), pick_duty());
            run_cycles($urandom_range(0, 1500));
            if (r == 0) begin
                fault = 1'b1;
                cycle();
                fault    = 1'b0;
                run_cycles($urandom_range(1, 20));
                faultClr = 1'b1;
                cycle();
                faultClr = 1'b0;
            end else if (r == 1) begin
                enable = 1'b0;
                run_cycles($urandom_range(1, 30));
                enable = 1'b1;
            end
            run_cycles($urandom_range(20, 300));
        end

        // Short raw pulses around the bottom restart the dead interval.
        write_duty(2, 1, 3);
        run_cycles(2100);

        // Asynchronous reset between clock edges.
        run_cycles(137);
        #20;
        nRst = 1'b0;
        #1;
        check("rst_async_H", 32'(pwmH), 32'd0);
        check("rst_async_L", 32'(pwmL), 32'd0);
        check("rst_async_sync", 32'(syncPulse), 32'd0);
        check("rst_async_fault", 32'(faultLatched), 32'd0);
        model_reset();
        @(negedge clk10mhz);
        run_cycles(2);
        nRst = 1'b1;
        run_cycles(1200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
